// File: rtl/bcd_ascii_pkg.sv
// bcd_ascii_pkg: shared BCD/ASCII character constants for the BCD-to-ASCII and line-transmit stages.
// Rev 1.0
`default_nettype none

package bcd_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_PAD  = 8'h5F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/ascii_line_tx.sv
// ascii_line_tx: latches an ASCII digit buffer and streams it, highest index first, plus optional CR/LF.
// Rev 1.0
`default_nettype none

module ascii_line_tx
  import bcd_ascii_pkg::*;
#(
  parameter int NUM_DIGITS = 10,
  parameter int ABITS      = 8,
  parameter int BUF_BITS   = NUM_DIGITS * ABITS,
  parameter bit SEND_CRLF  = 1'b1,
  parameter bit SKIP_PAD   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUF_BITS-1:0] ascii,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ABITS-1:0]    tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEND_DIGIT = 3'd1,
    S_SEND_CR    = 3'd2,
    S_SEND_LF    = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam int                IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [ABITS-1:0]  c_PAD      = ABITS'(ASCII_PAD);
  localparam logic [ABITS-1:0]  c_CR       = ABITS'(ASCII_CR);
  localparam logic [ABITS-1:0]  c_LF       = ABITS'(ASCII_LF);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [ABITS-1:0] r_buf [NUM_DIGITS];
  logic             w_load;
  logic [ABITS-1:0] w_char;
  logic             w_skip;
  logic             w_advance;
  logic             w_busy;
  logic             w_done;
  logic             w_tx_valid;
  logic [ABITS-1:0] w_tx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          r_buf[i] <= ascii[i*ABITS +: ABITS];
        end
      end
    end
  end

  // A skipped pad consumes one cycle exactly like an accepted transfer.
  always_comb begin
    w_char    = r_buf[r_idx];
    w_skip    = SKIP_PAD && (w_char == c_PAD);
    w_advance = w_skip || tx_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_tx_valid  = 1'b0;
    w_tx_data   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_idx_nxt   = c_LAST_IDX;
          w_state_nxt = S_SEND_DIGIT;
        end
      end
      S_SEND_DIGIT: begin
        w_busy     = 1'b1;
        w_tx_valid = !w_skip;
        w_tx_data  = w_char;
        if (w_advance) begin
          if (r_idx == '0) begin
            w_state_nxt = SEND_CRLF ? S_SEND_CR : S_DONE;
          end else begin
            w_idx_nxt = r_idx - 1'b1;
          end
        end
      end
      S_SEND_CR: begin
        w_busy     = 1'b1;
        w_tx_valid = 1'b1;
        w_tx_data  = c_CR;
        if (tx_ready) begin
          w_state_nxt = S_SEND_LF;
        end
      end
      S_SEND_LF: begin
        w_busy     = 1'b1;
        w_tx_valid = 1'b1;
        w_tx_data  = c_LF;
        if (tx_ready) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  assign busy     = w_busy;
  assign done     = w_done;
  assign tx_valid = w_tx_valid;
  assign tx_data  = w_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_ascii_line_tx.sv
// tb_ascii_line_tx: three parameter variants driven in parallel, checked against a line-level reference model.
// Rev 1.0
`default_nettype none

module tb_ascii_line_tx;
  import bcd_ascii_pkg::*;

  localparam int ND = 4;
  localparam int NI = 3;   // 0: CRLF, 1: CRLF + skip pads, 2: no CRLF

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              tx_ready;
  logic [ND*8-1:0]   ascii;
  logic [NI-1:0]     busy;
  logic [NI-1:0]     done;
  logic [NI-1:0]     tx_valid;
  logic [7:0]        tx_data [NI];

  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascii_line_tx #(.NUM_DIGITS(ND), .ABITS(8), .SEND_CRLF(1'b1), .SKIP_PAD(1'b0)) u_crlf (
    .clk(clk), .reset(reset), .ascii(ascii), .start(start), .busy(busy[0]), .done(done[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready));
  ascii_line_tx #(.NUM_DIGITS(ND), .ABITS(8), .SEND_CRLF(1'b1), .SKIP_PAD(1'b1)) u_skip (
    .clk(clk), .reset(reset), .ascii(ascii), .start(start), .busy(busy[1]), .done(done[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready));
  ascii_line_tx #(.NUM_DIGITS(ND), .ABITS(8), .SEND_CRLF(1'b0), .SKIP_PAD(1'b0)) u_nocrlf (
    .clk(clk), .reset(reset), .ascii(ascii), .start(start), .busy(busy[2]), .done(done[2]),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Observed traffic, recorded on the falling edge for the transfer at the next rising edge.
  logic [7:0] rx [NI][64];
  int         rx_n [NI];
  int         done_cnt [NI];
  int         done_cyc [NI];
  int         first_v [NI];
  int         last_t [NI];
  int         vcnt [NI];
  bit         hold [NI];
  logic [7:0] held [NI];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (reset) begin
          hold[i] = 1'b0;
        end else begin
          if (hold[i]) begin
            check("stall_hold_valid", {31'd0, tx_valid[i]}, 32'd1);
            check("stall_hold_data", {24'd0, tx_data[i]}, {24'd0, held[i]});
          end
          if (tx_valid[i]) begin
            vcnt[i]++;
            if (first_v[i] < 0) first_v[i] = cyc;
            check("valid_implies_busy", {31'd0, busy[i]}, 32'd1);
          end
          if (tx_valid[i] && tx_ready) begin
            if (rx_n[i] < 64) rx[i][rx_n[i]] = tx_data[i];
            rx_n[i]++;
            last_t[i] = cyc;
          end
          if (done[i]) begin
            done_cnt[i]++;
            done_cyc[i] = cyc;
            check("done_with_busy", {31'd0, busy[i]}, 32'd1);
            check("done_no_valid", {31'd0, tx_valid[i]}, 32'd0);
          end
          hold[i] = tx_valid[i] && !tx_ready;
          held[i] = tx_data[i];
        end
      end
    end
  end

  // Reference model: the line is the buffer read from the top character down, pads optionally dropped, CR/LF optionally appended.
  logic [7:0] exp_c [NI][8];
  int         exp_n [NI];

  task automatic build_exp(input logic [ND*8-1:0] d);
    logic [7:0] c;
    for (int i = 0; i < NI; i++) begin
      exp_n[i] = 0;
      for (int p = ND - 1; p >= 0; p--) begin
        c = d[p*8 +: 8];
        if (!(i == 1 && c == ASCII_PAD)) begin
          exp_c[i][exp_n[i]] = c;
          exp_n[i] = exp_n[i] + 1;
        end
      end
      if (i != 2) begin
        exp_c[i][exp_n[i]]     = ASCII_CR;
        exp_c[i][exp_n[i] + 1] = ASCII_LF;
        exp_n[i] = exp_n[i] + 2;
      end
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < NI; i++) begin
      rx_n[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
      first_v[i] = -1; last_t[i] = -1; vcnt[i] = 0;
    end
  endtask

  function automatic logic rdy(input int mode, input int ph);
    case (mode)
      0:       return 1'b1;
      1:       return (ph % 3) == 2;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // mode 0: ready high, 1: ready 0,0,1 repeating, 2: random ready.
  // sidx >= 0 pulses a second start on the cycle k+sidx.
  task automatic run_line(input logic [ND*8-1:0] d, input int mode, input bit chg, input int sidx);
    int k, t, ph, lp;
    bit all_done;
    clear_mon();
    build_exp(d);
    ascii    = d;
    start    = 1'b1;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
    if (chg) ascii = 32'h39393939;
    ph = 0;
    t  = 0;
    all_done = 1'b0;
    while (t < 200 && !all_done) begin
      start    = (sidx >= 0) && (cyc == k + sidx);
      tx_ready = rdy(mode, ph);
      @(posedge clk); #1;
      t++;
      ph++;
      all_done = (done_cnt[0] > 0) && (done_cnt[1] > 0) && (done_cnt[2] > 0);
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    check("line_complete", {31'd0, all_done}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("len_inst%0d", i), rx_n[i], exp_n[i]);
      for (int j = 0; j < exp_n[i] && j < rx_n[i]; j++)
        check($sformatf("char_inst%0d_pos%0d", i, j), {24'd0, rx[i][j]}, {24'd0, exp_c[i][j]});
      check($sformatf("done_once_inst%0d", i), done_cnt[i], 1);
      check($sformatf("idle_busy_inst%0d", i), {31'd0, busy[i]}, 32'd0);
    end
    if (mode == 0) begin
      lp = 0;
      while (lp < ND && d[(ND-1-lp)*8 +: 8] == ASCII_PAD) lp++;
      check("first_valid_cycle", first_v[0], k);
      check("last_transfer_cycle", last_t[0], k + ND + 1);
      check("done_cycle", done_cyc[0], k + ND + 2);
      check("skip_first_valid_cycle", first_v[1], k + lp);
      check("skip_done_cycle", done_cyc[1], k + ND + 2);
      check("nocrlf_done_cycle", done_cyc[2], k + ND);
    end
    if (mode == 1) check("stall_valid_cycles", vcnt[0], 3 * (ND + 2));
  endtask

  task automatic reset_mid_line();
    clear_mon();
    ascii    = 32'h5F5F3432;
    tx_ready = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_valid_inst%0d", i), {31'd0, tx_valid[i]}, 32'd0);
      check($sformatf("rst_busy_inst%0d", i), {31'd0, busy[i]}, 32'd0);
      check($sformatf("rst_done_inst%0d", i), {31'd0, done[i]}, 32'd0);
      check($sformatf("rst_data_inst%0d", i), {24'd0, tx_data[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_count_inst0", rx_n[0], 2);
    check("rst_count_inst1", rx_n[1], 0);
    check("rst_count_inst2", rx_n[2], 2);
    check("rst_char1_inst0", {24'd0, rx[0][1]}, {24'd0, ASCII_PAD});
    for (int i = 0; i < NI; i++)
      check($sformatf("rst_no_done_inst%0d", i), done_cnt[i], 0);
  endtask

  initial begin
    logic [ND*8-1:0] d;
    int v;
    reset    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    ascii    = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_busy_inst%0d", i), {31'd0, busy[i]}, 32'd0);
      check($sformatf("reset_valid_inst%0d", i), {31'd0, tx_valid[i]}, 32'd0);
      check($sformatf("reset_done_inst%0d", i), {31'd0, done[i]}, 32'd0);
      check($sformatf("reset_data_inst%0d", i), {24'd0, tx_data[i]}, 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    run_line(32'h5F5F3432, 0, 1'b0, -1);
    run_line(32'h5F5F3432, 1, 1'b0, -1);
    run_line(32'h5F5F3432, 1, 1'b1, 2);
    run_line(32'h5F5F3432, 0, 1'b1, 4);
    run_line(32'h30303030, 0, 1'b0, -1);
    reset_mid_line();
    @(posedge clk); #1;

    for (int n = 0; n < 12; n++) begin
      for (int p = 0; p < ND; p++) begin
        v = $urandom_range(0, 10);
        d[p*8 +: 8] = (v == 10) ? ASCII_PAD : (ASCII_ZERO + 8'(v));
      end
      run_line(d, (n % 4 == 0) ? 0 : 2, 1'($urandom_range(0, 1)),
               $urandom_range(0, 1) ? $urandom_range(0, 3) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
